// File: rtl/triloc_bmr_sched.sv
// triloc_bmr_sched: sequencer for the TriLoc BMR trilateration core.
//
// Collects anchor A/B/C coordinates and the Q radii word through four independent
// valid/ready slots. It holds the collected operands on core_p0..core_p3 and waits
// CORE_LAT settle cycles. It then samples core_o and presents the signed position
// on a valid/ready result port.
//
// Build option: define TRILOC_DIV3_EN to include a sequential divide-by-3 of both
// coordinates. Without it, the raw core output is forwarded.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   pK_valid/pK_ready/pK_data  party offers, K=0..2 ({x,y}, 2N bits), K=3 ({rA,rB,rC}, 3N+3)
//   core_p0..core_p3         registered operands driven into the core
//   core_o                   core result {xM[N+3:0], yM[N+3:0]}, signed
//   res_valid/res_ready      result handshake
//   res_x, res_y             signed result coordinates (N+4 bits)
//   busy                     high whenever not collecting operands
module triloc_bmr_sched #(
    parameter int unsigned N        = 8,
    parameter int unsigned CORE_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             p0_valid,
    output logic             p0_ready,
    input  logic [2*N-1:0]   p0_data,
    input  logic             p1_valid,
    output logic             p1_ready,
    input  logic [2*N-1:0]   p1_data,
    input  logic             p2_valid,
    output logic             p2_ready,
    input  logic [2*N-1:0]   p2_data,
    input  logic             p3_valid,
    output logic             p3_ready,
    input  logic [3*N+2:0]   p3_data,
    output logic [2*N-1:0]   core_p0,
    output logic [2*N-1:0]   core_p1,
    output logic [2*N-1:0]   core_p2,
    output logic [3*N+2:0]   core_p3,
    input  logic [2*N+7:0]   core_o,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [N+3:0]     res_x,
    output logic [N+3:0]     res_y,
    output logic             busy
);

    localparam int unsigned CntW = (CORE_LAT < 2) ? 1 : $clog2(CORE_LAT + 1);

    typedef enum logic [2:0] {
        StCollect,
        StWait,
        StCapture,
        StDiv,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        full_q, full_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [3:0]        ready_vec;
    logic [3:0]        accept;
    logic [N+3:0]      core_x, core_y;
    logic [N+3:0]      res_x_q, res_y_q;

    assign ready_vec = (state_q == StCollect) ? ~full_q : 4'b0000;
    assign accept    = {p3_valid, p2_valid, p1_valid, p0_valid} & ready_vec;
    assign p0_ready  = ready_vec[0];
    assign p1_ready  = ready_vec[1];
    assign p2_ready  = ready_vec[2];
    assign p3_ready  = ready_vec[3];
    assign res_valid = (state_q == StDone);
    assign busy      = (state_q != StCollect);
    assign res_x     = res_x_q;
    assign res_y     = res_y_q;
    assign core_x    = core_o[2*N+7:N+4];
    assign core_y    = core_o[N+3:0];

`ifdef TRILOC_DIV3_EN
    localparam int unsigned DivW = $clog2(N + 4);

    logic [N+3:0]    qx_q, qy_q;
    logic [1:0]      rx_q, ry_q;
    logic            negx_q, negy_q;
    logic [DivW-1:0] dcnt_q;
    logic [N+5:0]    stepx, stepy;
    logic            div_last;

    // One restoring step: shift the next dividend bit into the remainder and
    // shift the quotient bit in at the bottom of the same register.
    function automatic logic [N+5:0] div_step(input logic [N+3:0] q, input logic [1:0] r);
        logic [2:0] t;
        logic [2:0] d;
        t = {r, q[N+3]};
        d = t - 3'd3;
        if (t >= 3'd3) begin
            div_step = {d[1:0], q[N+2:0], 1'b1};
        end else begin
            div_step = {t[1:0], q[N+2:0], 1'b0};
        end
    endfunction

    assign stepx    = div_step(qx_q, rx_q);
    assign stepy    = div_step(qy_q, ry_q);
    assign div_last = (dcnt_q == DivW'(N + 3));
`endif

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        full_d  = full_q;
        cnt_d   = cnt_q;
        case (state_q)
            StCollect: begin
                full_d = full_q | accept;
                if (&full_d) begin
                    state_d = StWait;
                    cnt_d   = '0;
                end
            end
            StWait: begin
                if (cnt_q == CntW'(CORE_LAT - 1)) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCapture: begin
`ifdef TRILOC_DIV3_EN
                state_d = StDiv;
`else
                state_d = StDone;
`endif
            end
            StDiv: begin
`ifdef TRILOC_DIV3_EN
                if (div_last) begin
                    state_d = StDone;
                end
`else
                state_d = StCollect;
`endif
            end
            StDone: begin
                if (res_ready) begin
                    state_d = StCollect;
                    full_d  = '0;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StCollect;
            full_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            full_q  <= full_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operand slots: written only on acceptance, so they stay stable until the
    // next collection overwrites them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_p0 <= '0;
            core_p1 <= '0;
            core_p2 <= '0;
            core_p3 <= '0;
        end else begin
            if (accept[0]) core_p0 <= p0_data;
            if (accept[1]) core_p1 <= p1_data;
            if (accept[2]) core_p2 <= p2_data;
            if (accept[3]) core_p3 <= p3_data;
        end
    end

`ifdef TRILOC_DIV3_EN
    // Divide sign-magnitude: the magnitude of -2^(N+3) wraps to itself, which is
    // correct when read as unsigned N+4 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qx_q    <= '0;
            qy_q    <= '0;
            rx_q    <= '0;
            ry_q    <= '0;
            negx_q  <= 1'b0;
            negy_q  <= 1'b0;
            dcnt_q  <= '0;
            res_x_q <= '0;
            res_y_q <= '0;
        end else begin
            case (state_q)
                StCapture: begin
                    negx_q <= core_x[N+3];
                    negy_q <= core_y[N+3];
                    qx_q   <= core_x[N+3] ? -core_x : core_x;
                    qy_q   <= core_y[N+3] ? -core_y : core_y;
                    rx_q   <= '0;
                    ry_q   <= '0;
                    dcnt_q <= '0;
                end
                StDiv: begin
                    qx_q   <= stepx[N+3:0];
                    qy_q   <= stepy[N+3:0];
                    rx_q   <= stepx[N+5:N+4];
                    ry_q   <= stepy[N+5:N+4];
                    dcnt_q <= dcnt_q + 1'b1;
                    if (div_last) begin
                        res_x_q <= negx_q ? -stepx[N+3:0] : stepx[N+3:0];
                        res_y_q <= negy_q ? -stepy[N+3:0] : stepy[N+3:0];
                    end
                end
                default: ;
            endcase
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_x_q <= '0;
            res_y_q <= '0;
        end else if (state_q == StCapture) begin
            res_x_q <= core_x;
            res_y_q <= core_y;
        end
    end
`endif

endmodule

// File: tb/tb_triloc_bmr_sched.sv
// Self-checking bench for triloc_bmr_sched (N=8, CORE_LAT=2). The core is a stub:
// either a forced constant or a fixed arithmetic mix of the operand words.
module tb_triloc_bmr_sched;

    localparam int unsigned N  = 8;
    localparam int unsigned CL = 2;
`ifdef TRILOC_DIV3_EN
    localparam int LAT = CL + N + 5;
`else
    localparam int LAT = CL + 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_valid, p1_valid, p2_valid, p3_valid;
    logic        p0_ready, p1_ready, p2_ready, p3_ready;
    logic [15:0] p0_data, p1_data, p2_data;
    logic [26:0] p3_data;
    logic [15:0] core_p0, core_p1, core_p2;
    logic [26:0] core_p3;
    logic [23:0] core_o;
    logic        res_valid, res_ready, busy;
    logic [11:0] res_x, res_y;

    logic        stub_force;
    logic [23:0] stub_val;

    int checks = 0;
    int errors = 0;

    triloc_bmr_sched #(.N(N), .CORE_LAT(CL)) dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_data(p0_data),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_data(p1_data),
        .p2_valid(p2_valid), .p2_ready(p2_ready), .p2_data(p2_data),
        .p3_valid(p3_valid), .p3_ready(p3_ready), .p3_data(p3_data),
        .core_p0(core_p0), .core_p1(core_p1), .core_p2(core_p2), .core_p3(core_p3),
        .core_o(core_o),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_x(res_x), .res_y(res_y), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] stub_fn(input logic [15:0] a, input logic [15:0] b,
                                            input logic [15:0] c, input logic [26:0] q);
        logic [11:0] x, y;
        x = 12'(a[15:8]) + 12'(b[7:0]) - 12'(q[26:18]);
        y = {a[3:0], c[7:0]} ^ 12'(q[8:0]) ^ {b[15:8], c[11:8]};
        return {x, y};
    endfunction

    assign core_o = stub_force ? stub_val : stub_fn(core_p0, core_p1, core_p2, core_p3);

    // Reference result: signed truncating division by 3, or pass-through.
    function automatic logic [11:0] ref_coord(input logic [11:0] v);
`ifdef TRILOC_DIV3_EN
        int i;
        i = int'($signed(v));
        return 12'(i / 3);
`else
        return v;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_valids();
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        p2_valid = 1'b0;
        p3_valid = 1'b0;
    endtask

    task automatic offer_all(input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] c, input logic [26:0] q);
        p0_valid = 1'b1; p0_data = a;
        p1_valid = 1'b1; p1_data = b;
        p2_valid = 1'b1; p2_data = c;
        p3_valid = 1'b1; p3_data = q;
        tick();
        clear_valids();
    endtask

    // Called just after the edge where the last slot filled.
    task automatic wait_result(input string tag, input logic [11:0] ex, input logic [11:0] ey);
        int n;
        n = 0;
        while (!res_valid && n < 200) begin
            tick();
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(LAT));
        chk({tag, " res_x"}, 32'(res_x), 32'(ex));
        chk({tag, " res_y"}, 32'(res_y), 32'(ey));
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    logic [11:0] ex, ey;
    logic [26:0] rec [4];
    logic [3:0]  got;
    logic [23:0] mix;

    initial begin
        rst = 1'b1;
        res_ready = 1'b0;
        stub_force = 1'b1;
        stub_val = '0;
        p0_data = '0; p1_data = '0; p2_data = '0; p3_data = '0;
        clear_valids();
        tick();
        tick();
        chk("reset outputs", 32'({p3_ready, p2_ready, p1_ready, p0_ready, busy, res_valid,
                                  res_x, res_y}), 32'({4'hF, 1'b0, 1'b0, 24'h0}));
        chk("reset core_p", 32'(|{core_p0, core_p1, core_p2, core_p3}), 32'(0));
        rst = 1'b0;
        tick();

        // All four offers in one cycle, fixed core output 300 / -301.
        stub_val = {12'sd300, -12'sd301};
        offer_all(16'hA1B2, 16'hC3D4, 16'hE5F6, 27'h1234567);
        chk("t1 busy", 32'({busy, p0_ready, p1_ready, p2_ready, p3_ready}), 32'(5'b10000));
        chk("t1 core_p3", 32'(core_p3), 32'(27'h1234567));
`ifdef TRILOC_DIV3_EN
        ex = 12'd100; ey = -12'sd100;
`else
        ex = 12'd300; ey = -12'sd301;
`endif
        wait_result("t1", ex, ey);

        // Backpressure: result held, no slot ready.
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (!res_valid || res_x !== ex || res_y !== ey ||
                    {p0_ready, p1_ready, p2_ready, p3_ready} !== 4'b0) bad++;
            end
            chk("t3 hold stable", 32'(bad), 32'(0));
        end
        res_ready = 1'b1;
        #1;
        chk("t3 no bypass", 32'({p0_ready, p1_ready, p2_ready, p3_ready}), 32'(0));
        tick();
        res_ready = 1'b0;
        chk("t3 ready after hs", 32'({p0_ready, p1_ready, p2_ready, p3_ready, res_valid, busy}),
            32'(6'b111100));

        // Staggered offers p3, p0, (p0 again), p2, p1; core stub follows operands.
        stub_force = 1'b0;
        p3_valid = 1'b1; p3_data = 27'h2A5C3E1; tick(); clear_valids();
        tick();
        p0_valid = 1'b1; p0_data = 16'hF091; tick(); clear_valids();
        chk("t2 p0_ready after fill", 32'(p0_ready), 32'(0));
        p0_valid = 1'b1; p0_data = 16'h1234; tick(); clear_valids();
        chk("t2 core_p0 kept", 32'(core_p0), 32'(16'hF091));
        p2_valid = 1'b1; p2_data = 16'h7E81; tick(); clear_valids();
        tick();
        chk("t2 busy before p1", 32'(busy), 32'(0));
        p1_valid = 1'b1; p1_data = 16'h3C69; tick(); clear_valids();
        chk("t2 busy after p1", 32'(busy), 32'(1));
        mix = stub_fn(16'hF091, 16'h3C69, 16'h7E81, 27'h2A5C3E1);
        wait_result("t2", ref_coord(mix[23:12]), ref_coord(mix[11:0]));
        handshake();

        // Boundary quotients.
        stub_force = 1'b1;
        stub_val = {12'h800, 12'h7FF};
        offer_all(16'h0001, 16'h0002, 16'h0003, 27'h4);
`ifdef TRILOC_DIV3_EN
        wait_result("t4 extreme", -12'sd682, 12'd682);
`else
        wait_result("t4 extreme", 12'h800, 12'h7FF);
`endif
        handshake();
        stub_val = {-12'sd2, 12'sd3};
        offer_all(16'h0005, 16'h0006, 16'h0007, 27'h8);
`ifdef TRILOC_DIV3_EN
        wait_result("t4 small", 12'd0, 12'd1);
`else
        wait_result("t4 small", -12'sd2, 12'd3);
`endif
        handshake();

        // Reset in the middle of an operation.
        stub_val = {12'sd90, 12'sd45};
        offer_all(16'h1111, 16'h2222, 16'h3333, 27'h4444);
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5 reset outputs", 32'({p3_ready, p2_ready, p1_ready, p0_ready, busy, res_valid,
                                     res_x, res_y}), 32'({4'hF, 1'b0, 1'b0, 24'h0}));
        chk("t5 reset core_p", 32'(|{core_p0, core_p1, core_p2, core_p3}), 32'(0));
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 25; i++) begin
                tick();
                if (res_valid) seen++;
            end
            chk("t5 no stale valid", 32'(seen), 32'(0));
        end
        stub_val = {-12'sd999, 12'sd1000};
        offer_all(16'h5555, 16'h6666, 16'h7777, 27'h888);
        wait_result("t5 after reset", ref_coord(-12'sd999), ref_coord(12'sd1000));
        handshake();

        // Randomized operations with independent offers and re-offers.
        stub_force = 1'b0;
        for (int op = 0; op < 15; op++) begin
            int cyc;
            got = 4'b0;
            cyc = 0;
            while (got != 4'hF && cyc < 200) begin
                logic [3:0] v;
                logic [26:0] d [4];
                for (int k = 0; k < 4; k++) begin
                    d[k] = 27'($urandom());
                    v[k] = got[k] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) == 0);
                    if (v[k] && !got[k]) begin
                        got[k] = 1'b1;
                        rec[k] = d[k];
                    end
                end
                p0_valid = v[0]; p0_data = d[0][15:0];
                p1_valid = v[1]; p1_data = d[1][15:0];
                p2_valid = v[2]; p2_data = d[2][15:0];
                p3_valid = v[3]; p3_data = d[3];
                tick();
                cyc++;
            end
            clear_valids();
            chk("rnd operands", 32'({core_p0 ^ core_p1 ^ core_p2, core_p3 == rec[3]}),
                32'({rec[0][15:0] ^ rec[1][15:0] ^ rec[2][15:0], 1'b1}));
            mix = stub_fn(rec[0][15:0], rec[1][15:0], rec[2][15:0], rec[3]);
            wait_result("rnd", ref_coord(mix[23:12]), ref_coord(mix[11:0]));
            for (int w = $urandom_range(0, 3); w > 0; w--) tick();
            handshake();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
